pc_sequencer: RTL and testbench

//  Program-counter controller for the CPU fetch path. Owns the PC and sequences fetch -> decode -> PC update.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_target_calc.sv | 22 ++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, default
// reset/trap addresses and a small alignment helper.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PsIdle   = 2'd0,
    PsFetch  = 2'd1,
    PsDecode = 2'd2,
    PsHalt   = 2'd3
  } ps_state_e;

  localparam logic [31:0] DefResetPc    = 32'h0000_0000;
  localparam logic [31:0] DefTrapVector = 32'h0000_0180;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch and J-format targets.
module pc_target_calc (
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm_ext,
  input  logic [25:0] i_jump_index,
  output logic [31:0] o_pc4,
  output logic [31:0] o_br,
  output logic [31:0] o_jmp
);

  // Top two offset bits fall off when the word offset is scaled to bytes.
  logic w_unused_imm;
  assign w_unused_imm = ^i_imm_ext[31:30];

  // All additions are 32-bit modulo; carries are discarded on purpose.
  always_comb begin
    o_pc4 = i_pc + 32'd4;
    o_br  = o_pc4 + {i_imm_ext[29:0], 2'b00};
    o_jmp = {o_pc4[31:28], i_jump_index, 2'b00};
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC and sequences fetch -> decode -> PC update.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned next PC redirects to TRAP_VECTOR
// and pulses trap); when undefined the next PC is force-aligned and trap is tied 0.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DefResetPc,
  parameter logic [31:0] TRAP_VECTOR = DefTrapVector
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        dec_valid,
  input  logic        is_branch,
  input  logic        br_cond,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic        is_link,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        link_we,
  output logic        halted,
  output logic        trap
);

  ps_state_e   r_state;
  ps_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic        r_halt_pend;
  logic        w_halt_any;
  logic        w_pc_load;
  logic [31:0] w_pc4;
  logic [31:0] w_br;
  logic [31:0] w_jmp;
  logic [31:0] w_sel;
  logic [31:0] w_pc_nxt;

  pc_target_calc u_target_calc (
    .i_pc         (r_pc),
    .i_imm_ext    (imm_ext),
    .i_jump_index (jump_index),
    .o_pc4        (w_pc4),
    .o_br         (w_br),
    .o_jmp        (w_jmp)
  );

  // A same-cycle halt request counts as pending so it is never lost at a retire edge.
  assign w_halt_any = r_halt_pend | halt_req;

  // Next-PC source select; flags are not guaranteed one-hot, so priority decides.
  always_comb begin
    w_sel = w_pc4;
    if (is_jr) begin
      w_sel = jr_target;
    end else if (is_jump) begin
      w_sel = w_jmp;
    end else if (is_branch && br_cond) begin
      w_sel = w_br;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_trap;

  assign w_misalign = is_misaligned(w_sel);
  assign w_pc_nxt   = w_misalign ? TRAP_VECTOR : w_sel;
  assign trap       = r_trap;

  // Trap pulse lines up with the cycle in which the PC shows the trap vector.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= w_pc_load & w_misalign;
    end
  end
`else
  logic w_unused_trap_vec;

  assign w_unused_trap_vec = ^TRAP_VECTOR;
  assign w_pc_nxt          = {w_sel[31:2], 2'b00};
  assign trap              = 1'b0;
`endif

  // FSM next state and handshake/pulse outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    link_we     = 1'b0;
    link_addr   = 32'h0;
    unique case (r_state)
      PsIdle: begin
        if (w_halt_any) begin
          w_state_nxt = PsHalt;
        end else if (run_en) begin
          w_state_nxt = PsFetch;
        end
      end
      PsFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          w_state_nxt = PsDecode;
        end
      end
      PsDecode: begin
        if (dec_valid) begin
          w_pc_load = 1'b1;
          if (is_link) begin
            link_we   = 1'b1;
            link_addr = w_pc4;
          end
          if (w_halt_any) begin
            w_state_nxt = PsHalt;
          end else if (run_en) begin
            w_state_nxt = PsFetch;
          end else begin
            w_state_nxt = PsIdle;
          end
        end
      end
      PsHalt: begin
        w_state_nxt = PsHalt;
      end
      default: begin
        w_state_nxt = PsIdle;
      end
    endcase
  end

  // State, PC and sticky halt-pending registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PsIdle;
      r_pc        <= RESET_PC;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (halt_req) begin
        r_halt_pend <= 1'b1;
      end
      if (w_pc_load) begin
        r_pc <= w_pc_nxt;
      end
    end
  end

  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign halted    = (r_state == PsHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random instruction mix
// checked against an arithmetic reference of the next-PC rules.
module tb_pc_sequencer;

  logic        clock;
  logic        rst_n;
  logic        run_en;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        dec_valid;
  logic        is_branch;
  logic        br_cond;
  logic        is_jump;
  logic        is_jr;
  logic        is_link;
  logic [31:0] imm_ext;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        link_we;
  logic        halted;
  logic        trap;

  int n_assert;
  int n_fail;
  logic [31:0] m_pc;

  pc_sequencer dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .run_en      (run_en),
    .halt_req    (halt_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .dec_valid   (dec_valid),
    .is_branch   (is_branch),
    .br_cond     (br_cond),
    .is_jump     (is_jump),
    .is_jr       (is_jr),
    .is_link     (is_link),
    .imm_ext     (imm_ext),
    .jump_index  (jump_index),
    .jr_target   (jr_target),
    .pc          (pc),
    .link_addr   (link_addr),
    .link_we     (link_we),
    .halted      (halted),
    .trap        (trap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference next PC straight from the selection rules (modulo-2^32 arithmetic).
  task automatic model_next(input logic f_br, input logic f_cond, input logic f_j,
                            input logic f_jr, input logic [31:0] imm,
                            input logic [25:0] jidx, input logic [31:0] jrt,
                            output logic [31:0] nxt, output logic exp_trap);
    logic [31:0] p4;
    logic [31:0] tgt;
    p4 = m_pc + 32'd4;
    if (f_jr) tgt = jrt;
    else if (f_j) tgt = (p4 & 32'hF000_0000) | (32'(jidx) * 32'd4);
    else if (f_br && f_cond) tgt = p4 + imm * 32'd4;
    else tgt = p4;
`ifdef MISALIGN_TRAP_EN
    exp_trap = (tgt % 4) != 0;
    nxt = exp_trap ? 32'h0000_0180 : tgt;
`else
    exp_trap = 1'b0;
    nxt = tgt - (tgt % 4);
`endif
  endtask

  // Runs one instruction; entry and exit on a falling edge with the DUT fetching.
  task automatic run_instr(input int ack_dly, input int dec_dly, input logic do_halt,
                           input logic f_br, input logic f_cond, input logic f_j,
                           input logic f_jr, input logic f_link, input logic [31:0] imm,
                           input logic [25:0] jidx, input logic [31:0] jrt);
    logic [31:0] nxt;
    logic        exp_trap;
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    halt_req = do_halt;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clock);
      halt_req = 1'b0;
      chk("fetch_wait_req", {31'b0, imem_req}, 32'd1);
      chk("fetch_wait_iv", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    #1 chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    @(negedge clock);
    imem_ack = 1'b0;
    halt_req = 1'b0;
    chk("decode_req", {31'b0, imem_req}, 32'd0);
    chk("decode_iv", {31'b0, instr_valid}, 32'd0);
    repeat (dec_dly) @(negedge clock);
    dec_valid  = 1'b1;
    is_branch  = f_br;
    br_cond    = f_cond;
    is_jump    = f_j;
    is_jr      = f_jr;
    is_link    = f_link;
    imm_ext    = imm;
    jump_index = jidx;
    jr_target  = jrt;
    model_next(f_br, f_cond, f_j, f_jr, imm, jidx, jrt, nxt, exp_trap);
    #1 chk("link_we", {31'b0, link_we}, {31'b0, f_link});
    if (f_link) chk("link_addr", link_addr, m_pc + 32'd4);
    @(negedge clock);
    dec_valid = 1'b0;
    is_branch = 1'b0;
    br_cond   = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    is_link   = 1'b0;
    chk("next_pc", pc, nxt);
    chk("trap", {31'b0, trap}, {31'b0, exp_trap});
    m_pc = nxt;
  endtask

  initial begin
    logic [31:0] rimm;
    logic [31:0] rjrt;
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    run_en     = 1'b0;
    halt_req   = 1'b0;
    imem_ack   = 1'b0;
    dec_valid  = 1'b0;
    is_branch  = 1'b0;
    br_cond    = 1'b0;
    is_jump    = 1'b0;
    is_jr      = 1'b0;
    is_link    = 1'b0;
    imm_ext    = 32'h0;
    jump_index = 26'h0;
    jr_target  = 32'h0;
    m_pc       = 32'h0;

    // Reset state.
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_iv", {31'b0, instr_valid}, 32'd0);
    chk("rst_link_we", {31'b0, link_we}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    @(negedge clock);
    rst_n  = 1'b1;
    run_en = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clock);

    // Straight-line fetch: 0,4,8,12.
    for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc", pc, 32'h10);

    // Branch taken / not taken from 0x40.
    run_instr(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h40);
    run_instr(0, 1, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFFE, 0, 0);
    chk("br_taken", pc, 32'h3C);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h40);
    run_instr(0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0);
    chk("br_not_taken", pc, 32'h44);

    // JAL in the upper region.
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h9000_0010);
    run_instr(0, 0, 0, 0, 0, 1, 0, 1, 0, 26'h10, 0);
    chk("jal_pc", pc, 32'h9000_0040);

    // JR beats J; misaligned JR target.
    run_instr(0, 0, 0, 0, 0, 1, 1, 0, 0, 26'h3, 32'h200);
    chk("jr_prio", pc, 32'h200);
    run_instr(0, 0, 0, 0, 0, 1, 1, 0, 0, 26'h3, 32'h202);
`ifdef MISALIGN_TRAP_EN
    chk("mis_pc", pc, 32'h180);
    chk("mis_trap", {31'b0, trap}, 32'd1);
`else
    chk("mis_pc", pc, 32'h200);
    chk("mis_trap", {31'b0, trap}, 32'd0);
`endif
    @(negedge clock);
    chk("trap_cleared", {31'b0, trap}, 32'd0);
    // That extra cycle used one fetch wait; the task tolerates it via imem_req check.

    // Address wrap.
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);

    // run_en dropped mid-instruction: retire, then idle.
    run_en = 1'b0;
    run_instr(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_after_run_off", {31'b0, imem_req}, 32'd0);
    @(negedge clock);
    chk("idle_stays", {31'b0, imem_req}, 32'd0);
    chk("idle_not_halted", {31'b0, halted}, 32'd0);
    run_en = 1'b1;
    @(negedge clock);

    // Random instruction mix.
    for (int i = 0; i < 40; i++) begin
      rimm = {{16{1'b0}}, 16'($urandom)};
      if (rimm[15]) rimm[31:16] = 16'hFFFF;
      rjrt = $urandom;
      if ($urandom_range(0, 5) != 0) rjrt[1:0] = 2'b00;
      run_instr($urandom_range(0, 2), $urandom_range(0, 2), 0,
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), 1'($urandom), rimm, 26'($urandom), rjrt);
      if (trap) @(negedge clock);
    end

    // Halt pulse during a stretched fetch.
    run_instr(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_req_low", {31'b0, imem_req}, 32'd0);
    repeat (3) @(negedge clock);
    chk("halt_sticky", {31'b0, halted}, 32'd1);
    chk("halt_req_stays_low", {31'b0, imem_req}, 32'd0);
    chk("halt_pc_held", pc, m_pc);

    // Reset exits HALT; then reset lands mid-decode.
    rst_n = 1'b0;
    #1 chk("rst_halt_pc", pc, 32'h0);
    chk("rst_halt_halted", {31'b0, halted}, 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    m_pc  = 32'h0;
    @(negedge clock);
    run_instr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h500);
    imem_ack = 1'b1;
    @(negedge clock);
    imem_ack  = 1'b0;
    dec_valid = 1'b1;
    is_link   = 1'b1;
    #1 chk("pre_rst_link_we", {31'b0, link_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_link_we", {31'b0, link_we}, 32'd0);
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_iv", {31'b0, instr_valid}, 32'd0);
    chk("async_pc", pc, 32'h0);
    dec_valid = 1'b0;
    is_link   = 1'b0;
    run_en    = 1'b0;

    // Halt from IDLE goes straight to HALT.
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;
    run_en   = 1'b1;
    chk("idle_halt", {31'b0, halted}, 32'd1);
    @(negedge clock);
    chk("idle_halt_no_req", {31'b0, imem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
